// File: rtl/greenflow_status_encoder.sv
// GreenFlow status code producer: classifies a load metric into NORMAL/WARN/CRIT with
// persistence, hysteresis and minimum hold; FAULT overrides. Optional STATUS_FAULT_LATCH_EN makes FAULT sticky.
module greenflow_status_encoder #(
   parameter int W        = 8,
   parameter int WARN_TH  = 96,
   parameter int CRIT_TH  = 192,
   parameter int HYST     = 16,
   parameter int PERSIST  = 4,
   parameter int HOLD_CYC = 1000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sample_valid,
   input  logic [W-1:0] load_sample,
   input  logic         fault_in,
   input  logic         fault_clear,
   output logic [1:0]   status_code,
   output logic         status_chg
);

   localparam int WP = W + 1;
   localparam int PW = $clog2(PERSIST + 1);
   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam logic [WP-1:0] WARN_RAW  = WP'(WARN_TH);
   localparam logic [WP-1:0] CRIT_RAW  = WP'(CRIT_TH);
   localparam logic [WP-1:0] WARN_HYST = WP'(WARN_TH - HYST);
   localparam logic [WP-1:0] CRIT_HYST = WP'(CRIT_TH - HYST);
   localparam logic [PW-1:0] PERSIST_V = PW'(PERSIST);
   localparam logic [HW-1:0] HOLD_V    = HW'(HOLD_CYC);

   typedef enum logic [1:0] {
      LVL_NORMAL = 2'b00,
      LVL_WARN   = 2'b01,
      LVL_CRIT   = 2'b10,
      LVL_FAULT  = 2'b11
   } level_t;

   level_t        level_r, level_s;
   logic [PW-1:0] up_cnt_r, up_cnt_s;
   logic [PW-1:0] dn_cnt_r, dn_cnt_s;
   logic [HW-1:0] hold_cnt_r, hold_cnt_s;
   logic          status_chg_r;
   logic [1:0]    raw_lvl_s, hyst_lvl_s;
   logic [WP-1:0] sample_ext_s;

   // Threshold classification; operands are one bit wider than the sample so thresholds never wrap.
   function automatic logic [1:0] classify(input logic [WP-1:0] s,
                                           input logic [WP-1:0] warn_v,
                                           input logic [WP-1:0] crit_v);
      logic [1:0] lvl;
      if (s >= crit_v) begin
         lvl = 2'd2;
      end else if (s >= warn_v) begin
         lvl = 2'd1;
      end else begin
         lvl = 2'd0;
      end
      return lvl;
   endfunction

   assign sample_ext_s = {1'b0, load_sample};
   assign raw_lvl_s    = classify(sample_ext_s, WARN_RAW, CRIT_RAW);
   assign hyst_lvl_s   = classify(sample_ext_s, WARN_HYST, CRIT_HYST);

`ifndef STATUS_FAULT_LATCH_EN
   logic unused_fault_clear_s;
   assign unused_fault_clear_s = fault_clear;
`endif

   // Next-level decision and counter updates
   always_comb begin
      level_s    = level_r;
      up_cnt_s   = up_cnt_r;
      dn_cnt_s   = dn_cnt_r;
      hold_cnt_s = (hold_cnt_r == HOLD_V) ? hold_cnt_r : hold_cnt_r + 1'b1;

      if (fault_in) begin
         level_s    = LVL_FAULT;
         up_cnt_s   = {PW{1'b0}};
         dn_cnt_s   = {PW{1'b0}};
         hold_cnt_s = {HW{1'b0}};
      end else if (level_r == LVL_FAULT) begin
`ifdef STATUS_FAULT_LATCH_EN
         if (fault_clear) begin
            level_s = LVL_NORMAL;
         end else begin
            level_s = LVL_FAULT;
         end
`else
         level_s = LVL_NORMAL;
`endif
         up_cnt_s   = {PW{1'b0}};
         dn_cnt_s   = {PW{1'b0}};
         hold_cnt_s = {HW{1'b0}};
      end else begin
         if (sample_valid) begin
            up_cnt_s = (raw_lvl_s > level_r) ? up_cnt_r + 1'b1 : {PW{1'b0}};
            if (hyst_lvl_s < level_r) begin
               dn_cnt_s = (dn_cnt_r == PERSIST_V) ? dn_cnt_r : dn_cnt_r + 1'b1;
            end else begin
               dn_cnt_s = {PW{1'b0}};
            end
         end else begin
            up_cnt_s = up_cnt_r;
            dn_cnt_s = dn_cnt_r;
         end

         // Escalation jumps straight to the sample's level; downgrade steps one level after the hold
         if (sample_valid && (raw_lvl_s > level_r) && (up_cnt_s == PERSIST_V)) begin
            level_s = level_t'(raw_lvl_s);
         end else if ((dn_cnt_s == PERSIST_V) && (hold_cnt_s == HOLD_V)) begin
            level_s = level_t'(level_r - 2'd1);
         end else begin
            level_s = level_r;
         end
      end
   end

   // Level, counters and change pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_r      <= LVL_NORMAL;
         up_cnt_r     <= {PW{1'b0}};
         dn_cnt_r     <= {PW{1'b0}};
         hold_cnt_r   <= {HW{1'b0}};
         status_chg_r <= 1'b0;
      end else if (level_s != level_r) begin
         level_r      <= level_s;
         up_cnt_r     <= {PW{1'b0}};
         dn_cnt_r     <= {PW{1'b0}};
         hold_cnt_r   <= {HW{1'b0}};
         status_chg_r <= 1'b1;
      end else begin
         level_r      <= level_s;
         up_cnt_r     <= up_cnt_s;
         dn_cnt_r     <= dn_cnt_s;
         hold_cnt_r   <= hold_cnt_s;
         status_chg_r <= 1'b0;
      end
   end

   assign status_code = level_r;
   assign status_chg  = status_chg_r;

endmodule

// File: tb/tb_greenflow_status_encoder.sv
// Scoreboard bench for greenflow_status_encoder (HOLD_CYC=16); honours STATUS_FAULT_LATCH_EN.
module tb_greenflow_status_encoder;

   localparam int HOLD    = 16;
   localparam int PERSIST = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sample_valid;
   logic [7:0] load_sample;
   logic       fault_in;
   logic       fault_clear;
   logic [1:0] status_code;
   logic       status_chg;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_q[$];
   int m_lvl, m_up, m_dn, m_hold;

   greenflow_status_encoder #(.HOLD_CYC(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .load_sample(load_sample),
      .fault_in(fault_in), .fault_clear(fault_clear),
      .status_code(status_code), .status_chg(status_chg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference behaviour for one clock edge; pushes {code, chg}
   task automatic model_edge(input logic v, input int s, input logic fi, input logic fc);
      int raw, hy, nl, h;
      raw = (s >= 192) ? 2 : (s >= 96) ? 1 : 0;
      hy  = (s >= 176) ? 2 : (s >= 80) ? 1 : 0;
      nl  = m_lvl;
      h   = (m_hold < HOLD) ? m_hold + 1 : HOLD;
      if (fi) nl = 3;
      else if (m_lvl == 3) begin
`ifdef STATUS_FAULT_LATCH_EN
         nl = fc ? 0 : 3;
`else
         nl = 0;
`endif
      end else begin
         if (v) begin
            m_up = (raw > m_lvl) ? m_up + 1 : 0;
            if (hy < m_lvl) m_dn = (m_dn < PERSIST) ? m_dn + 1 : PERSIST;
            else m_dn = 0;
         end
         if (v && raw > m_lvl && m_up == PERSIST) nl = raw;
         else if (m_dn == PERSIST && h == HOLD) nl = m_lvl - 1;
      end
      m_hold = h;
      exp_q.push_back({2'(nl), (nl != m_lvl)});
      if (nl != m_lvl || nl == 3) begin
         m_up = 0; m_dn = 0; m_hold = 0;
      end
      m_lvl = nl;
   endtask

   task automatic cycle(input logic v, input int s, input logic fi, input logic fc);
      logic [2:0] e;
      sample_valid = v; load_sample = 8'(s); fault_in = fi; fault_clear = fc;
      model_edge(v, s, fi, fc);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check_val("code", int'(status_code), int'(e[2:1]));
      check_val("chg", int'(status_chg), int'(e[0]));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; sample_valid = 1'b0; load_sample = 8'd0; fault_in = 1'b0; fault_clear = 1'b0;
      #1;
      check_val("rst_code", int'(status_code), 0);
      check_val("rst_chg", int'(status_chg), 0);
      m_lvl = 0; m_up = 0; m_dn = 0; m_hold = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic repeat_sample(input int n, input int s);
      for (int i = 0; i < n; i++) cycle(1'b1, s, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      int first0;
      int base;
      rst_n = 1'b1;
      #2;
      apply_reset();

      // NORMAL holds on a low sample, then WARN after four samples of 100
      cycle(1'b1, 50, 1'b0, 1'b0);
      check_val("low_stays_normal", int'(status_code), 0);
      repeat_sample(3, 100);
      check_val("warn_not_yet", int'(status_code), 0);
      cycle(1'b1, 100, 1'b0, 1'b0);
      check_val("warn_entered", int'(status_code), 1);
      check_val("warn_chg", int'(status_chg), 1);
      apply_reset();

      // Interrupted run does not escalate
      repeat_sample(3, 100);
      cycle(1'b1, 50, 1'b0, 1'b0);
      cycle(1'b1, 100, 1'b0, 1'b0);
      check_val("broken_run", int'(status_code), 0);
      cycle(1'b1, 50, 1'b0, 1'b0);

      // Direct NORMAL -> CRIT
      repeat_sample(4, 200);
      check_val("direct_crit", int'(status_code), 2);
      check_val("direct_crit_chg", int'(status_chg), 1);
      idle(1);
      check_val("crit_chg_single", int'(status_chg), 0);
      apply_reset();

      // Hysteresis in WARN after the hold
      repeat_sample(4, 100);
      idle(20);
      repeat_sample(8, 85);
      check_val("hyst_hold_warn", int'(status_code), 1);
      repeat_sample(3, 70);
      check_val("hyst_not_yet", int'(status_code), 1);
      cycle(1'b1, 70, 1'b0, 1'b0);
      check_val("hyst_down", int'(status_code), 0);

      // Early downgrade waits for the hold to expire
      repeat_sample(4, 100);
      first0 = 0;
      for (int i = 1; i <= 24; i++) begin
         if (i >= 3 && i <= 6) cycle(1'b1, 70, 1'b0, 1'b0);
         else cycle(1'b0, 0, 1'b0, 1'b0);
         if (first0 == 0 && status_code == 2'b00) first0 = i;
      end
      check_val("hold_step_cycle", first0, 16);
      apply_reset();

      // CRIT steps down one level at a time
      repeat_sample(4, 200);
      idle(20);
      repeat_sample(3, 10);
      check_val("crit_not_yet", int'(status_code), 2);
      cycle(1'b1, 10, 1'b0, 1'b0);
      check_val("crit_to_warn", int'(status_code), 1);
      repeat_sample(15, 10);
      check_val("warn_held", int'(status_code), 1);
      cycle(1'b1, 10, 1'b0, 1'b0);
      check_val("warn_to_normal", int'(status_code), 0);
      apply_reset();

      // Fault pulse while in WARN
      repeat_sample(4, 100);
      idle(2);
      cycle(1'b0, 0, 1'b1, 1'b0);
      check_val("fault_enter", int'(status_code), 3);
      check_val("fault_enter_chg", int'(status_chg), 1);
`ifdef STATUS_FAULT_LATCH_EN
      idle(3);
      check_val("fault_sticky", int'(status_code), 3);
      cycle(1'b0, 0, 1'b1, 1'b1);
      check_val("clear_ignored", int'(status_code), 3);
      cycle(1'b0, 0, 1'b0, 1'b1);
      check_val("fault_cleared", int'(status_code), 0);
      check_val("fault_exit_chg", int'(status_chg), 1);
`else
      cycle(1'b0, 0, 1'b0, 1'b0);
      check_val("fault_exit", int'(status_code), 0);
      check_val("fault_exit_chg", int'(status_chg), 1);
      idle(1);
      check_val("fault_chg_done", int'(status_chg), 0);
`endif

      // Mixed traffic around the thresholds, checked cycle by cycle
      base = 20;
      for (int i = 0; i < 600; i++) begin
         int s;
         if (i % 40 == 0) begin
            case ($urandom_range(0, 4))
               0: base = 20;
               1: base = 88;
               2: base = 110;
               3: base = 180;
               default: base = 215;
            endcase
         end
         s = base + int'($urandom_range(0, 30)) - 15;
         cycle(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 79) == 0),
               1'($urandom_range(0, 3) == 0));
      end

      check_val("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/greenflow_status_encoder.md
Name: greenflow_status_encoder

Overview:
Producer side of the 2-bit GreenFlow status code consumed by the LED status indicator. Classifies a sampled load metric (intersection occupancy/congestion) into NORMAL/WARN/CRIT and applies a FAULT override. Persistence filtering, hysteresis and a minimum hold time keep the code from flickering. Sits between the occupancy aggregator and the LED status indicator; the status_code output drives the indicator's status_code input directly.

Parameters:
W, 8, width of load sample
WARN_TH, 96, raw threshold for WARN (load >= WARN_TH)
CRIT_TH, 192, raw threshold for CRIT (load >= CRIT_TH); must be > WARN_TH
HYST, 16, hysteresis subtracted from thresholds for downgrade; must be <= WARN_TH
PERSIST, 4, consecutive qualifying samples needed to change level (>= 1)
HOLD_CYC, 1000, minimum clocks spent in a level before any downgrade (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_valid  in  1  load_sample qualifier, one sample per high cycle
load_sample  in  W  unsigned load metric
fault_in  in  1  system fault request, level-sensitive
fault_clear  in  1  fault acknowledge; used only when STATUS_FAULT_LATCH_EN is defined
status_code  out  2  00 NORMAL, 01 WARN, 10 CRIT, 11 FAULT; registered
status_chg  out  1  one-cycle pulse, asserted in the first cycle a new status_code is valid

Behaviour:
- Reset (async assert, sync release): status_code=00, status_chg=0, up_cnt=dn_cnt=hold_cnt=0.
- State register holds the level. status_code equals the level encoding, so it is glitch-free.
- Raw level of a sample: 2 if s>=CRIT_TH, 1 if s>=WARN_TH, else 0.
- Hyst level of a sample: 2 if s>=CRIT_TH-HYST, 1 if s>=WARN_TH-HYST, else 0. Compare at W+1 bits so there is no underflow.
- hold_cnt increments every clock, saturates at HOLD_CYC, clears on any level change.
- Escalate (NORMAL/WARN/CRIT), per valid sample:
  - raw > current: up_cnt++.
  - Otherwise: up_cnt=0.
  - When up_cnt reaches PERSIST, the next state is the raw level of that sample. Direct 00->10 is allowed. Not gated by hold_cnt.
- Downgrade, per valid sample:
  - hyst < current: dn_cnt++, saturating at PERSIST.
  - Otherwise: dn_cnt=0.
  - When dn_cnt==PERSIST and hold_cnt==HOLD_CYC, step down exactly one level.
  - If dn_cnt saturates before the hold expires, the step occurs on the clock where hold_cnt reaches HOLD_CYC, unless a contradicting sample arrives in that same cycle (that sample clears dn_cnt, no step).
- Simultaneous escalate and downgrade qualification cannot occur: raw > current and hyst < current are mutually exclusive.
- sample_valid=0: up_cnt and dn_cnt hold; hold_cnt keeps counting.
- Any level change clears up_cnt, dn_cnt and hold_cnt.
- Latency: status_code changes on the clock edge after the deciding sample is presented (1 cycle).
- FAULT has highest priority:
  - fault_in=1 at an edge: next status_code=11 regardless of samples or counters. Counters clear.
  - In FAULT, samples are ignored and counters are held at 0.
  - Exit from FAULT always goes to NORMAL (00) with counters cleared; re-escalation needs PERSIST fresh samples.
- status_chg=1 exactly when status_code differs from its previous value; never asserted when re-entering the same level.

Optional Feature:
STATUS_FAULT_LATCH_EN:
- Defined: FAULT is sticky. Exit only on a clock with fault_clear=1 and fault_in=0. fault_clear while fault_in=1 is ignored, and fault_clear outside FAULT has no effect.
- Undefined: fault_clear is unused. FAULT exits on the first clock edge where fault_in=0, so FAULT lasts as long as fault_in plus one cycle of latency.

Test Plan (HOLD_CYC=16, other parameters default):
- Reset checks:
  - Assert rst_n=0 mid-WARN -> status_code=00 and status_chg=0 immediately (asynchronously).
  - After release, a valid sample of 50 -> status_code stays 00.
- Four consecutive valid samples of 100 -> status_code=01 one cycle after the 4th, status_chg pulses once. Samples 100,100,100,50,100 -> status_code stays 00.
- Four valid samples of 200 from NORMAL -> status_code=10 directly, single status_chg pulse.
- Hysteresis in WARN after hold expires:
  - Eight samples of 85 (>=80) -> status_code stays 01.
  - Four samples of 70 -> status_code=00.
  - Four samples of 70 issued 3 cycles after entering WARN -> status_code changes to 00 only on the cycle hold_cnt reaches 16.
- Downgrade from CRIT: samples of 10 after the hold -> 10->01 first (one step). A second PERSIST + hold window later -> 01->00.
- fault_in pulsed 1 cycle while in WARN:
  - Macro undefined -> 11 for one cycle, then 00, two status_chg pulses.
  - Macro defined -> 11 held. fault_clear with fault_in=1 is ignored. fault_clear with fault_in=0 -> 00 next cycle.
